// File: rtl/button_matrix_scanner.sv
// Charlieplexed 12-button keypad scanner on a 4-pin bidirectional port.
// Drives one pin low per phase, senses the other three, debounces per full scan frame.
module button_matrix_scanner #(
   parameter int unsigned PHASE_CYCLES   = 1024,
   parameter int unsigned DEBOUNCE_SCANS = 4
) (
   input  logic        clk_i,
   input  logic        rst_i,
   inout  wire  [3:0]  b_io,
   output logic [11:0] button_o
);

   localparam int unsigned PW = $clog2(PHASE_CYCLES);
   localparam int unsigned CW = (DEBOUNCE_SCANS > 1) ? $clog2(DEBOUNCE_SCANS) : 1;

   logic [3:0]           sync_meta_q, sync_meta_d;
   logic [3:0]           sync_q, sync_d;
   logic [1:0]           drive_q, drive_d;
   logic [PW-1:0]        ph_cnt_q, ph_cnt_d;
   logic [11:0]          raw_q, raw_d;
   logic [11:0][CW-1:0]  cnt_q, cnt_d;
   logic [11:0]          button_q, button_d;
   logic                 sample;
   logic                 scan_done;
   logic [2:0]           sensed;

   // Pins float during reset; otherwise only the current drive pin is pulled low.
   for (genvar g = 0; g < 4; g++) begin : g_pin
      assign b_io[g] = (!rst_i && drive_q == 2'(g)) ? 1'b0 : 1'bz;
   end

   always_comb begin
      sync_meta_d = b_io;
      sync_d      = sync_meta_q;
      sample      = (ph_cnt_q == PW'(PHASE_CYCLES - 1));
      scan_done   = sample && (drive_q == 2'd3);
      ph_cnt_d    = sample ? '0 : ph_cnt_q + 1'b1;
      drive_d     = sample ? drive_q + 2'd1 : drive_q;

      // Sense pins in ascending order, skipping the driven one; pressed reads low.
      case (drive_q)
         2'd0:    sensed = ~{sync_q[3], sync_q[2], sync_q[1]};
         2'd1:    sensed = ~{sync_q[3], sync_q[2], sync_q[0]};
         2'd2:    sensed = ~{sync_q[3], sync_q[1], sync_q[0]};
         default: sensed = ~{sync_q[2], sync_q[1], sync_q[0]};
      endcase

      raw_d = raw_q;
      if (sample) begin
         raw_d[3*int'(drive_q) +: 3] = sensed;
      end

      // raw_d already carries this edge's drive-3 bits, so it is the full new frame.
      button_d = button_q;
      cnt_d    = cnt_q;
      if (scan_done) begin
         for (int unsigned i = 0; i < 12; i++) begin
            if (raw_d[i] != button_q[i]) begin
               if (cnt_q[i] == CW'(DEBOUNCE_SCANS - 1)) begin
                  button_d[i] = ~button_q[i];
                  cnt_d[i]    = '0;
               end else begin
                  cnt_d[i] = cnt_q[i] + 1'b1;
               end
            end else begin
               cnt_d[i] = '0;
            end
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sync_meta_q <= '1;
         sync_q      <= '1;
         drive_q     <= '0;
         ph_cnt_q    <= '0;
         raw_q       <= '0;
         cnt_q       <= '0;
         button_q    <= '0;
      end else begin
         sync_meta_q <= sync_meta_d;
         sync_q      <= sync_d;
         drive_q     <= drive_d;
         ph_cnt_q    <= ph_cnt_d;
         raw_q       <= raw_d;
         cnt_q       <= cnt_d;
         button_q    <= button_d;
      end
   end

   assign button_o = button_q;

endmodule

// File: tb/tb_button_matrix_scanner.sv
// Bench for button_matrix_scanner: pulled-up pins, diode-style key model, and a
// frame-history debounce reference; pins and outputs compared every cycle.
module tb_button_matrix_scanner;

   localparam int PH = 8;
   localparam int DB = 2;

   logic        clk = 1'b0;
   logic        rst;
   wire  [3:0]  b_io;
   logic [11:0] button;

   logic [11:0] press;
   logic [1:0]  drv_m;
   logic [3:0]  pull_lo;
   logic [11:0] out_m;
   logic [11:0] hist[$];
   int          checks = 0;
   int          errors = 0;

   button_matrix_scanner #(.PHASE_CYCLES(PH), .DEBOUNCE_SCANS(DB)) dut (
      .clk_i   (clk),
      .rst_i   (rst),
      .b_io    (b_io),
      .button_o(button)
   );

   always #5 clk = ~clk;

   // Button (d, j) = bit 3*d + rank of j among the pins other than d.
   function automatic logic [3:0] sense_low(input logic [11:0] p, input logic [1:0] d);
      logic [3:0] lo;
      int dd;
      lo = 4'b0000;
      dd = int'(d);
      for (int k = 0; k < 3; k++) begin
         int j;
         j = (k < dd) ? k : k + 1;
         if (p[3*dd + k]) lo[j] = 1'b1;
      end
      return lo;
   endfunction

   always_comb pull_lo = sense_low(press, drv_m);

   for (genvar g = 0; g < 4; g++) begin : g_pad
      pullup pu (b_io[g]);
      assign b_io[g] = pull_lo[g] ? 1'b0 : 1'bz;
   end

   task automatic check_eq(input string tag, input logic [11:0] got, input logic [11:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h want %h at %0t", tag, got, exp, $time);
      end
   endtask

   // A bit flips once the last DB frame readings all disagree with the current output.
   task automatic model_scan();
      hist.push_back(press);
      if (hist.size() > DB) void'(hist.pop_front());
      if (hist.size() == DB) begin
         logic [11:0] nxt;
         nxt = out_m;
         for (int i = 0; i < 12; i++) begin
            logic all_diff;
            all_diff = 1'b1;
            foreach (hist[n]) if (hist[n][i] == out_m[i]) all_diff = 1'b0;
            if (all_diff) nxt[i] = ~out_m[i];
         end
         out_m = nxt;
      end
   endtask

   task automatic run_frame(input logic [11:0] p, input int stop_at);
      press = p;
      for (int e = 0; e < stop_at; e++) begin
         @(posedge clk);
         #1;
         if (e % PH == PH - 1) begin
            if (e == 4*PH - 1) model_scan();
            drv_m = drv_m + 2'd1;
         end
         #1;
         check_eq("pins", {8'h00, b_io}, {8'h00, ~((4'b0001 << drv_m) | pull_lo)});
         check_eq("button", button, out_m);
      end
   endtask

   task automatic do_reset();
      #1;
      rst   = 1'b1;
      press = '0;
      drv_m = 2'd0;
      #1;
      check_eq("rst_button", button, 12'h000);
      check_eq("rst_pins", {8'h00, b_io}, 12'h00F);
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_eq("rst_hold_button", button, 12'h000);
      check_eq("rst_hold_pins", {8'h00, b_io}, 12'h00F);
      out_m = '0;
      hist.delete();
      rst = 1'b0;
   endtask

   initial begin
      logic [11:0] p;
      rst   = 1'b1;
      press = '0;
      drv_m = 2'd0;
      out_m = '0;
      repeat (3) @(posedge clk);
      #1;
      check_eq("init_button", button, 12'h000);
      check_eq("init_pins", {8'h00, b_io}, 12'h00F);
      @(negedge clk);
      rst = 1'b0;

      repeat (10) run_frame(12'h000, 4*PH);

      do_reset();
      repeat (3) run_frame(12'h020, 4*PH);
      repeat (3) run_frame(12'h000, 4*PH);

      run_frame(12'h040, 4*PH);
      repeat (3) run_frame(12'h000, 4*PH);

      repeat (3) run_frame(12'h801, 4*PH);

      repeat (3) run_frame(12'h020, 4*PH);
      run_frame(12'h120, 4*PH);
      run_frame(12'h120, 10);
      check_eq("pre_rst_set", button, 12'h020);
      do_reset();
      repeat (3) run_frame(12'h120, 4*PH);

      p = 12'h000;
      for (int f = 0; f < 60; f++) begin
         if ($urandom_range(0, 3) == 0) p = 12'($urandom) & 12'($urandom);
         if ($urandom_range(0, 15) == 0) begin
            run_frame(p, int'($urandom_range(1, 4*PH - 1)));
            do_reset();
         end else begin
            run_frame(p, 4*PH);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
